// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//   Iterative RISC-V M-extension unit that borrows the pipeline's shared ALU.
//   Multiplication is shift-add with one ALU ADD per cycle. Division is
//   restoring, with one ALU SUB per cycle. The unit takes a fixed 35 cycles
//   from accept to done: IDLE, PREP, 32 x ITER, FIX, DONE.
//
//   Optional feature, enabled by defining MULDIV_EARLY_OUT_EN:
//     - Divide-by-zero and signed overflow go straight from PREP to FIX.
//     - A multiply with a zero operand does the same.
//     - In both cases done arrives in cycle 3.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start              M-ext op present in EX, held until done
//   kill               pipeline flush, abandons the in-flight op
//   funct3             operation select (MUL..REMU)
//   opA, opB           rs1 / rs2, sampled on accept only
//   stall              start & ~done
//   busy               high in every state except IDLE
//   done               one-cycle pulse, result valid that cycle
//   result             selected product / quotient / remainder word
//   alu_sel            this block owns the shared ALU (ITER states)
//   alu_op1, alu_op2   ALU operands, zero while alu_sel is low
//   alu_ctrl           4'b0000 ADD, 4'b0001 SUB
//   alu_out            shared ALU result (combinational)
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  kill,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] opA,
  input  logic [DATA_WIDTH-1:0] opB,
  output logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  alu_sel,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [3:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_out
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE, PREP, MUL_ITER, DIV_ITER, FIX, DONE
  } state_t;

  state_t       state;
  logic [2:0]   f3;
  logic [W-1:0] a_q, b_q;
  logic [W-1:0] mcand;      // multiplicand or divisor magnitude
  logic [2*W-1:0] acc;      // MUL: {product hi, product lo / multiplier}; DIV: {rem, quo}
  logic [5:0]   cnt;
  logic         neg_a, neg_b;
  logic         div_zero, div_ovf;

  // Combinational helpers
  logic           a_signed, b_signed;
  logic [W-1:0]   mag_a, mag_b;
  logic           div_zero_c, div_ovf_c, early;
  logic           carry;
  logic [2*W-1:0] mul_next, div_next;
  logic [W-1:0]   rem_sh;
  logic           ge;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo_fix, rem_fix, fix_word;

  assign stall = start & ~done;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    a_signed   = 1'b0;
    b_signed   = 1'b0;
    case (f3)
      3'b001:                 begin a_signed = 1'b1; b_signed = 1'b1; end // MULH
      3'b010:                 a_signed = 1'b1;                            // MULHSU
      3'b100, 3'b110:         begin a_signed = 1'b1; b_signed = 1'b1; end // DIV, REM
      default:                ;
    endcase
    mag_a      = (a_signed && a_q[W-1]) ? -a_q : a_q;
    mag_b      = (b_signed && b_q[W-1]) ? -b_q : b_q;
    div_zero_c = (b_q == '0);
    div_ovf_c  = ~f3[0] && (a_q == {1'b1, {(W-1){1'b0}}}) && (b_q == '1);
`ifdef MULDIV_EARLY_OUT_EN
    early      = f3[2] ? (div_zero_c | div_ovf_c) : ((a_q == '0) | (b_q == '0));
`else
    early      = 1'b0;
`endif
  end

  // ALU is driven only while this block owns it.
  always_comb begin
    alu_op1  = '0;
    alu_op2  = '0;
    alu_ctrl = 4'b0000;
    rem_sh   = acc[2*W-2:W-1];
    if (state == MUL_ITER) begin
      alu_op1 = acc[2*W-1:W];
      alu_op2 = mcand;
    end else if (state == DIV_ITER) begin
      alu_op1  = rem_sh;
      alu_op2  = mcand;
      alu_ctrl = 4'b0001;
    end
  end

  // Iteration steps
  always_comb begin
    // Unsigned wrap of the ADD means a carry out of the high word.
    carry    = (alu_out < alu_op1);
    mul_next = acc[0] ? {carry, alu_out, acc[W-1:1]}
                      : {1'b0, acc[2*W-1:W], acc[W-1:1]};
    // The bit shifted out of rem is the 33rd bit of the partial remainder.
    // If it is set, the remainder is at least the divisor, and the 32-bit
    // SUB result is exact.
    ge       = acc[2*W-1] | (rem_sh >= mcand);
    div_next = ge ? {alu_out, acc[W-2:0], 1'b1}
                  : {rem_sh,  acc[W-2:0], 1'b0};
  end

  // Sign fix-up and word select
  always_comb begin
    prod    = (neg_a ^ neg_b) ? -acc : acc;
    quo_fix = (neg_a ^ neg_b) ? -acc[W-1:0] : acc[W-1:0];
    rem_fix = neg_a ? -acc[2*W-1:W] : acc[2*W-1:W];
    if (div_zero) begin
      quo_fix = '1;
      rem_fix = a_q;
    end else if (div_ovf) begin
      quo_fix = {1'b1, {(W-1){1'b0}}};
      rem_fix = '0;
    end
    if (!f3[2])
      fix_word = (f3[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
    else
      fix_word = f3[1] ? rem_fix : quo_fix;
  end

  // NOTE: sequential state uses non-blocking assignments only. All
  // registers here are plain flops, so all of them are reset; there is no
  // RAM to leave uninitialised.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      alu_sel  <= 1'b0;
      result   <= '0;
      cnt      <= '0;
      acc      <= '0;
      f3       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand    <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
    end else if (kill) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_sel <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= PREP;
            busy  <= 1'b1;
            f3    <= funct3;
            a_q   <= opA;
            b_q   <= opB;
          end
        end
        PREP: begin
          neg_a    <= a_signed & a_q[W-1];
          neg_b    <= b_signed & b_q[W-1];
          div_zero <= f3[2] & div_zero_c;
          div_ovf  <= f3[2] & div_ovf_c;
          cnt      <= 6'(W);
          if (f3[2]) begin
            mcand <= mag_b;
            acc   <= {{W{1'b0}}, mag_a};   // dividend enters via quo
          end else begin
            mcand <= mag_a;
            acc   <= early ? '0 : {{W{1'b0}}, mag_b};
          end
          if (early) begin
            state <= FIX;
          end else begin
            state   <= f3[2] ? DIV_ITER : MUL_ITER;
            alu_sel <= 1'b1;
          end
        end
        MUL_ITER, DIV_ITER: begin
          acc <= (state == MUL_ITER) ? mul_next : div_next;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            state   <= FIX;
            alu_sel <= 1'b0;
          end
        end
        FIX: begin
          result <= fix_word;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          alu_sel <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
//   Directed bench for muldiv_ctrl.
//   - A local adder/subtractor plays the shared ALU.
//   - Expected results come from a behavioural reference model.
//   - Each expected result is queued when its op is launched and popped
//     when done is seen.
//   - Cycle 0 is the cycle in which start is first presented.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        stall, busy, done, alu_sel;
  logic [31:0] result, alu_op1, alu_op2, alu_out;
  logic [3:0]  alu_ctrl;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  assign alu_out = (alu_ctrl == 4'b0001) ? (alu_op1 - alu_op2) : (alu_op1 + alu_op2);

  muldiv_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .opA(op_a), .opB(op_b), .stall(stall), .busy(busy), .done(done),
    .result(result), .alu_sel(alu_sel), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_ctrl(alu_ctrl), .alu_out(alu_out)
  );

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 3;
`else
  localparam int EARLY_LAT = 35;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] xa, xb, sp;
    logic [63:0]        up;
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    model = '0;
    case (f)
      3'b000: begin up = {32'b0, a} * {32'b0, b}; model = up[31:0]; end
      3'b001: begin xa = {{32{a[31]}}, a}; xb = {{32{b[31]}}, b}; sp = xa * xb; model = sp[63:32]; end
      3'b010: begin xa = {{32{a[31]}}, a}; xb = {32'b0, b}; sp = xa * xb; model = sp[63:32]; end
      3'b011: begin up = {32'b0, a} * {32'b0, b}; model = up[63:32]; end
      3'b100: model = (b == 0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'(sa / sb);
      3'b101: model = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: model = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Launch one op and wait (bounded) for done, then check latency, result,
  // the stall profile and the one-cycle done pulse.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input string tag);
    int          cyc;
    bit          seen, stall_ok;
    logic [31:0] exp_res, held;
    sb_q.push_back(model(f, a, b));
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    #1;
    stall_ok = (stall === 1'b1);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) seen = 1;
      else if (stall !== 1'b1) stall_ok = 0;
    end
    if (seen && stall !== 1'b0) stall_ok = 0;
    held  = result;
    start = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    exp_res = sb_q.pop_front();
    check({tag, "_result"}, {32'b0, result}, {32'b0, exp_res});
    check({tag, "_stall"}, {63'b0, stall_ok}, 64'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, {62'b0, done, busy}, 64'd0);
    check({tag, "_result_hold"}, {32'b0, result}, {32'b0, held});
  endtask

  initial begin
    int cyc;
    bit bad_done;
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {result, 27'b0, busy, done, alu_sel, stall, 1'b0}, 64'd0);
    check("reset_alu_ops", {alu_op1, alu_op2}, 64'd0);
    rst = 1'b0;

    run_op(3'b000, 32'd7,        32'hFFFFFFFD, 35,        "mul_7x-3");
    run_op(3'b001, 32'h80000000, 32'h80000000, 35,        "mulh_min");
    run_op(3'b011, 32'h80000000, 32'h80000000, 35,        "mulhu_min");
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 35,        "mulhsu_neg1");
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 35,        "mulhu_max");
    run_op(3'b000, 32'd0,        32'd12345,    EARLY_LAT, "mul_zero");
    run_op(3'b100, 32'hFFFFFFF9, 32'd2,        35,        "div_-7_2");
    run_op(3'b110, 32'hFFFFFFF9, 32'd2,        35,        "rem_-7_2");
    run_op(3'b101, 32'd100,      32'd0,        EARLY_LAT, "divu_by0");
    run_op(3'b111, 32'd100,      32'd0,        EARLY_LAT, "remu_by0");
    run_op(3'b100, 32'hFFFFFFF9, 32'd0,        EARLY_LAT, "div_neg_by0");
    run_op(3'b110, 32'hFFFFFFF9, 32'd0,        EARLY_LAT, "rem_neg_by0");
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, EARLY_LAT, "div_ovf");
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, EARLY_LAT, "rem_ovf");
    run_op(3'b101, 32'hFFFFFFFF, 32'd3,        35,        "divu_max_3");
    run_op(3'b111, 32'd100,      32'd7,        35,        "remu_100_7");

    // Kill a DIVU in cycle 10; nothing may complete, and a MUL launched in
    // cycle 12 completes in cycle 47.
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    bad_done = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) bad_done = 1;
    end
    kill = 1'b1; start = 1'b0;
    @(negedge clk);
    kill = 1'b0;
    if (done === 1'b1) bad_done = 1;
    check("kill_busy_c11", {63'b0, busy}, 64'd0);
    check("kill_no_done", {63'b0, bad_done}, 64'd0);
    run_op(3'b000, 32'd123456, 32'd789, 35, "mul_after_kill");

    // Reset in cycle 20 of a MULH; start held relaunches the op in cycle 22.
    sb_q.push_back(model(3'b001, 32'hFFFF0001, 32'h00012345));
    @(negedge clk);
    funct3 = 3'b001; op_a = 32'hFFFF0001; op_b = 32'h00012345; start = 1'b1;
    for (int i = 1; i <= 20; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_outputs", {result, 29'b0, busy, done, alu_sel}, 64'd0);
    check("rst_mid_alu_ops", {alu_op1, alu_op2}, 64'd0);
    @(negedge clk);
    check("rst_relaunch_busy", {63'b0, busy}, 64'd1);
    cyc = 22;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("rst_relaunch_latency", 64'(cyc), 64'd56);
    check("rst_relaunch_result", {32'b0, result}, {32'b0, sb_q.pop_front()});
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  M-ext op present in EX; held high until done.
REQ-005 kill  in  1  pipeline flush; abandons the in-flight op.
REQ-006 funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 opA, opB  in  32  rs1, rs2 values; sampled only on accept.
REQ-008 stall  out  1  hold IF/ID/EX; equals start & ~done.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle pulse; result valid that cycle only.
REQ-011 result  out  32  selected product/quotient/remainder word.
REQ-012 alu_sel  out  1  high when the shared ALU is owned by this block (MUL_ITER, DIV_ITER).
REQ-013 alu_op1, alu_op2  out  32  ALU operands while alu_sel is high.
REQ-014 alu_ctrl  out  4  4'b0000 ADD in MUL_ITER, 4'b0001 SUB in DIV_ITER, 4'b0000 otherwise.
REQ-015 alu_out  in  32  shared ALU result, combinational from alu_op1/op2/ctrl.

Function
REQ-016 The FSM SHALL use states IDLE, PREP, MUL_ITER, DIV_ITER, FIX, DONE.
REQ-017 IDLE: start=1 & kill=0 -> PREP; latch funct3, opA, opB; start is ignored in all other states.
REQ-018 PREP (1 cycle): take magnitudes of signed operands (MULH: both; MULHSU: opA only; DIV/REM: both); clear 64-bit accumulator; load 6-bit counter with 32; go to MUL_ITER for funct3[2]=0, otherwise to DIV_ITER.
REQ-019 MUL_ITER: per cycle, when multiplier LSB=1, add the multiplicand to the accumulator high word via the ALU (ADD); carry = (alu_out < alu_op1) unsigned, computed locally; shift {carry, acc} right 1.
REQ-020 DIV_ITER: restoring division; per cycle shift {rem, quo} left 1; ALU SUBs divisor from rem; keep the difference and set quo LSB=1 when rem >= divisor (unsigned, local compare), else restore.
REQ-021 The counter SHALL decrement each ITER cycle; leave ITER for FIX when it reaches 0 (exactly 32 ITER cycles).
REQ-022 FIX (1 cycle): apply sign: product negated (64-bit) if operand signs differ; quotient negated if dividend and divisor signs differ; remainder takes the dividend sign; select the word per funct3 (MUL low; MULH/MULHSU/MULHU high).
REQ-023 DONE (1 cycle): assert done, drive result, then return to IDLE unconditionally.
REQ-024 Nominal latency: start accepted in cycle 0; done in cycle 35.
REQ-025 Divide by zero SHALL give quotient 32'hFFFFFFFF and remainder = opA, for signed and unsigned.
REQ-026 Signed overflow (opA=32'h80000000, opB=32'hFFFFFFFF) SHALL give quotient 32'h80000000 and remainder 0.
REQ-027 kill in any state SHALL force IDLE next cycle; no done pulse; kill takes priority over start.
REQ-028 result SHALL hold its last value outside DONE; consumers qualify it with done.
REQ-029 The ALU SHALL be driven only while alu_sel=1; ALU flags are unused.

Reset
REQ-030 rst=1 SHALL, at the next edge, force IDLE, busy=0, done=0, alu_sel=0, result=0, counter=0, accumulator=0, regardless of state (mid-operation included).
REQ-031 rst SHALL take priority over kill and start.

Configuration
REQ-032 With MULDIV_EARLY_OUT_EN defined, divide-by-zero and signed overflow SHALL bypass DIV_ITER (PREP -> FIX), giving done in cycle 3; opB=0 or opA=0 MUL ops SHALL also bypass MUL_ITER, giving result 0 in cycle 3.
REQ-033 Without MULDIV_EARLY_OUT_EN, all ops SHALL take the fixed 35-cycle latency; results are identical.

Verification
REQ-034 MUL opA=7, opB=-3 (32'hFFFFFFFD) -> done in cycle 35, result 32'hFFFFFFEB; stall high in cycles 0-34, low in cycle 35.
REQ-035 MULH opA=32'h80000000, opB=32'h80000000 -> result 32'h40000000; MULHU with the same operands -> 32'h40000000; MULHSU opA=-1, opB=32'hFFFFFFFF -> 32'hFFFFFFFF.
REQ-036 DIV opA=-7, opB=2 -> quotient 32'hFFFFFFFD; REM -> 32'hFFFFFFFF; DIVU opA=100, opB=0 -> 32'hFFFFFFFF; REMU -> 100.
REQ-037 DIV opA=32'h80000000, opB=-1 -> result 32'h80000000; with MULDIV_EARLY_OUT_EN, done in cycle 3, otherwise in cycle 35.
REQ-038 Start DIVU, assert kill in cycle 10 -> busy=0 in cycle 11, no done; a new MUL started in cycle 12 completes in cycle 47 with a correct result.
REQ-039 Assert rst in cycle 20 of a MULH -> all outputs at reset values in cycle 21; alu_sel=0; start held high relaunches the op in cycle 22.
